// File: rtl/benes_pipe_network.sv
// Pipelined N-port Benes permutation network with valid/ready flow control and a
// multi-context switch-setting memory. Each beat selects its context and carries a tag.
module benes_pipe_network #(
  parameter int DATA_WIDTH = 64,
  parameter int LOG_N      = 5,
  parameter int NUM_CTX    = 4,
  parameter int PIPE_EVERY = 1,
  parameter int TAG_W      = 8,
  localparam int N          = 1 << LOG_N,
  localparam int STAGES     = 2 * LOG_N - 1,
  localparam int SW         = N / 2,
  localparam int CTX_W      = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
  localparam int SW_STAGE_W = $clog2(STAGES)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_valid,
  output logic                            i_ready,
  input  logic [0:N-1][DATA_WIDTH-1:0]    i_data,
  input  logic [CTX_W-1:0]                i_ctx,
  input  logic [TAG_W-1:0]                i_tag,
  output logic                            o_valid,
  input  logic                            o_ready,
  output logic [0:N-1][DATA_WIDTH-1:0]    o_data,
  output logic [TAG_W-1:0]                o_tag,
  input  logic                            cfg_we,
  input  logic [CTX_W-1:0]                cfg_ctx,
  input  logic [SW_STAGE_W-1:0]           cfg_stage,
  input  logic [SW-1:0]                   cfg_data,
  output logic                            busy
);

  // Memory is sized to the full index range so reads never go out of bounds;
  // entries past NUM_CTX/STAGES are never written and stay all-bar.
  localparam int CTX_D = 1 << CTX_W;
  localparam int STG_D = 1 << SW_STAGE_W;

  // Source port feeding destination p after stage s (inverse of the stage's wiring).
  function automatic int src_idx(input int s, input int p);
    int blk;
    int base;
    int k;
    if (s < LOG_N - 1) blk = N >> s;
    else               blk = 1 << (s - LOG_N + 3);
    base = p - (p % blk);
    k    = p % blk;
    if (s < LOG_N - 1) src_idx = base + ((k < blk / 2) ? 2 * k : 2 * (k - blk / 2) + 1);
    else               src_idx = base + ((k % 2 == 0) ? k / 2 : blk / 2 + k / 2);
  endfunction

  function automatic bit is_boundary(input int s);
    return ((s + 1) % PIPE_EVERY == 0) || (s == STAGES - 1);
  endfunction

  logic                  adv;
  logic                  cfg_hit;
  logic [SW-1:0]         cfg_mem_q [CTX_D][STG_D];
  logic [SW-1:0]         cfg_mem_d [CTX_D][STG_D];
  logic [STAGES-1:0]     slot_valid;
  logic                  unused_last_ctx;

  assign cfg_hit = cfg_we && (int'(cfg_ctx) < NUM_CTX) && (int'(cfg_stage) < STAGES);

  always_comb begin
    cfg_mem_d = cfg_mem_q;
    if (cfg_hit) cfg_mem_d[cfg_ctx][cfg_stage] = cfg_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CTX_D; c++)
        for (int t = 0; t < STG_D; t++)
          cfg_mem_q[c][t] <= '0;
    end else begin
      cfg_mem_q <= cfg_mem_d;
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic                         in_v;
    logic [0:N-1][DATA_WIDTH-1:0] in_data;
    logic [CTX_W-1:0]             in_ctx;
    logic [TAG_W-1:0]             in_tag;
    logic                         out_v;
    logic [0:N-1][DATA_WIDTH-1:0] out_data;
    logic [CTX_W-1:0]             out_ctx;
    logic [TAG_W-1:0]             out_tag;
    logic [SW-1:0]                sel;
    logic [0:N-1][DATA_WIDTH-1:0] sw_data;
    logic [0:N-1][DATA_WIDTH-1:0] wr_data;

    if (s == 0) begin : g_src
      assign in_v    = i_valid;
      assign in_data = i_data;
      assign in_ctx  = i_ctx;
      assign in_tag  = i_tag;
    end else begin : g_chain
      assign in_v    = g_stage[s-1].out_v;
      assign in_data = g_stage[s-1].out_data;
      assign in_ctx  = g_stage[s-1].out_ctx;
      assign in_tag  = g_stage[s-1].out_tag;
    end

    // Setting follows the context of whichever beat currently occupies this stage.
    assign sel = cfg_mem_q[in_ctx][SW_STAGE_W'(s)];

    always_comb begin
      sw_data = in_data;
      for (int i = 0; i < SW; i++) begin
        if (sel[i]) begin
          sw_data[2*i]   = in_data[2*i+1];
          sw_data[2*i+1] = in_data[2*i];
        end
      end
    end

    if (s == STAGES - 1) begin : g_nowire
      assign wr_data = sw_data;
    end else begin : g_wire
      for (genvar p = 0; p < N; p++) begin : g_port
        localparam int SRC = src_idx(s, p);
        assign wr_data[p] = sw_data[SRC];
      end
    end

    if (is_boundary(s)) begin : g_reg
      logic                         slot_v_q, slot_v_d;
      logic [0:N-1][DATA_WIDTH-1:0] slot_data_q, slot_data_d;
      logic [CTX_W-1:0]             slot_ctx_q, slot_ctx_d;
      logic [TAG_W-1:0]             slot_tag_q, slot_tag_d;

      always_comb begin
        slot_v_d    = slot_v_q;
        slot_data_d = slot_data_q;
        slot_ctx_d  = slot_ctx_q;
        slot_tag_d  = slot_tag_q;
        if (adv) begin
          slot_v_d    = in_v;
          slot_data_d = wr_data;
          slot_ctx_d  = in_ctx;
          slot_tag_d  = in_tag;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_v_q    <= 1'b0;
          slot_data_q <= '0;
          slot_ctx_q  <= '0;
          slot_tag_q  <= '0;
        end else begin
          slot_v_q    <= slot_v_d;
          slot_data_q <= slot_data_d;
          slot_ctx_q  <= slot_ctx_d;
          slot_tag_q  <= slot_tag_d;
        end
      end

      assign out_v         = slot_v_q;
      assign out_data      = slot_data_q;
      assign out_ctx       = slot_ctx_q;
      assign out_tag       = slot_tag_q;
      assign slot_valid[s] = slot_v_q;
    end else begin : g_pass
      assign out_v         = in_v;
      assign out_data      = wr_data;
      assign out_ctx       = in_ctx;
      assign out_tag       = in_tag;
      assign slot_valid[s] = 1'b0;
    end
  end

  assign o_valid = g_stage[STAGES-1].out_v;
  assign o_data  = g_stage[STAGES-1].out_data;
  assign o_tag   = g_stage[STAGES-1].out_tag;
  assign unused_last_ctx = ^g_stage[STAGES-1].out_ctx;

  // The whole pipe advances together; it only holds when the output is occupied and refused.
  assign adv     = !o_valid || o_ready;
  assign i_ready = adv;
  assign busy    = |slot_valid;

endmodule

// File: tb/tb_benes_pipe_network.sv
// Directed bench: a 4-port single-stage-register network and an 8-port network
// with registers every second stage, both checked against hand-derived permutations.
module tb_benes_pipe_network;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic                a_i_valid, a_i_ready, a_o_valid, a_o_ready, a_cfg_we, a_busy;
  logic [0:3][DW-1:0]  a_i_data, a_o_data;
  logic [1:0]          a_i_ctx, a_cfg_ctx, a_cfg_stage, a_cfg_data;
  logic [7:0]          a_i_tag, a_o_tag;

  logic                b_i_valid, b_i_ready, b_o_valid, b_o_ready, b_cfg_we, b_busy;
  logic [0:7][DW-1:0]  b_i_data, b_o_data;
  logic [1:0]          b_i_ctx, b_cfg_ctx;
  logic [2:0]          b_cfg_stage;
  logic [3:0]          b_cfg_data;
  logic [7:0]          b_i_tag, b_o_tag;

  benes_pipe_network #(.DATA_WIDTH(DW), .LOG_N(2), .NUM_CTX(4), .PIPE_EVERY(1), .TAG_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .i_valid(a_i_valid), .i_ready(a_i_ready), .i_data(a_i_data),
    .i_ctx(a_i_ctx), .i_tag(a_i_tag), .o_valid(a_o_valid), .o_ready(a_o_ready),
    .o_data(a_o_data), .o_tag(a_o_tag), .cfg_we(a_cfg_we), .cfg_ctx(a_cfg_ctx),
    .cfg_stage(a_cfg_stage), .cfg_data(a_cfg_data), .busy(a_busy));

  benes_pipe_network #(.DATA_WIDTH(DW), .LOG_N(3), .NUM_CTX(4), .PIPE_EVERY(2), .TAG_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .i_valid(b_i_valid), .i_ready(b_i_ready), .i_data(b_i_data),
    .i_ctx(b_i_ctx), .i_tag(b_i_tag), .o_valid(b_o_valid), .o_ready(b_o_ready),
    .o_data(b_o_data), .o_tag(b_o_tag), .cfg_we(b_cfg_we), .cfg_ctx(b_cfg_ctx),
    .cfg_stage(b_cfg_stage), .cfg_data(b_cfg_data), .busy(b_busy));

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] a_ord [4];
  logic [15:0] rdy_pat;
  logic [63:0] exp_d_q [$];
  logic [7:0]  exp_t_q [$];

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Element e carries {seed, 0, source index}; ord lists source indices, element 0 first.
  function automatic logic [0:3][DW-1:0] av(input logic [7:0] seed, input logic [15:0] ord);
    logic [0:3][DW-1:0] r;
    for (int e = 0; e < 4; e++) r[e] = {seed, 4'h0, ord[15-4*e -: 4]};
    return r;
  endfunction

  function automatic logic [0:7][DW-1:0] bv(input logic [7:0] seed, input logic [31:0] ord);
    logic [0:7][DW-1:0] r;
    for (int e = 0; e < 8; e++) r[e] = {seed, 4'h0, ord[31-4*e -: 4]};
    return r;
  endfunction

  task automatic a_cfg(input logic [1:0] c, input logic [1:0] st, input logic [1:0] d);
    a_cfg_we = 1'b1; a_cfg_ctx = c; a_cfg_stage = st; a_cfg_data = d;
    tick();
    a_cfg_we = 1'b0;
  endtask

  task automatic b_cfg(input logic [1:0] c, input logic [2:0] st, input logic [3:0] d);
    b_cfg_we = 1'b1; b_cfg_ctx = c; b_cfg_stage = st; b_cfg_data = d;
    tick();
    b_cfg_we = 1'b0;
  endtask

  task automatic a_send(input logic [7:0] seed, input logic [1:0] c, input logic [7:0] t);
    a_i_valid = 1'b1; a_i_data = av(seed, 16'h0123); a_i_ctx = c; a_i_tag = t;
    tick();
    a_i_valid = 1'b0;
  endtask

  task automatic b_send(input logic [7:0] seed, input logic [1:0] c, input logic [7:0] t);
    b_i_valid = 1'b1; b_i_data = bv(seed, 32'h01234567); b_i_ctx = c; b_i_tag = t;
    tick();
    b_i_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, limit 100000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, got;
    logic stall_prev;
    logic [63:0] prev_d;
    logic [7:0]  prev_t;

    a_ord[0] = 16'h0123; a_ord[1] = 16'h1023; a_ord[2] = 16'h2103; a_ord[3] = 16'h0132;
    rdy_pat = 16'b1011_0010_1110_0101;
    rst_n = 1'b0;
    a_i_valid = 0; a_i_data = '0; a_i_ctx = 0; a_i_tag = 0; a_o_ready = 1;
    a_cfg_we = 0; a_cfg_ctx = 0; a_cfg_stage = 0; a_cfg_data = 0;
    b_i_valid = 0; b_i_data = '0; b_i_ctx = 0; b_i_tag = 0; b_o_ready = 1;
    b_cfg_we = 0; b_cfg_ctx = 0; b_cfg_stage = 0; b_cfg_data = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    chk("a_rst_o_valid", a_o_valid, 1'b0);
    chk("a_rst_o_data", a_o_data, '0);
    chk("a_rst_o_tag", a_o_tag, 8'h00);
    chk("a_rst_busy", a_busy, 1'b0);
    chk("a_rst_i_ready", a_i_ready, 1'b1);
    chk("b_rst_o_valid", b_o_valid, 1'b0);

    // identity through all-bar config, latency 3
    a_send(8'h01, 2'd0, 8'h5A);
    chk("a_id_busy", a_busy, 1'b1);
    chk("a_id_lat1", a_o_valid, 1'b0);
    tick();
    chk("a_id_lat2", a_o_valid, 1'b0);
    tick();
    chk("a_id_valid", a_o_valid, 1'b1);
    chk("a_id_data", a_o_data, av(8'h01, 16'h0123));
    chk("a_id_tag", a_o_tag, 8'h5A);
    tick();
    chk("a_id_pulse", a_o_valid, 1'b0);
    chk("a_id_idle", a_busy, 1'b0);

    // back-to-back beats on different contexts
    a_cfg(2'd1, 2'd0, 2'b01);
    a_send(8'h02, 2'd1, 8'h11);
    a_send(8'h03, 2'd0, 8'h12);
    tick();
    chk("a_sw0_valid", a_o_valid, 1'b1);
    chk("a_sw0_data", a_o_data, av(8'h02, 16'h1023));
    chk("a_sw0_tag", a_o_tag, 8'h11);
    tick();
    chk("a_ctx0_data", a_o_data, av(8'h03, 16'h0123));
    chk("a_ctx0_tag", a_o_tag, 8'h12);

    // middle-stage and last-stage switches
    a_cfg(2'd2, 2'd1, 2'b01);
    a_cfg(2'd3, 2'd2, 2'b10);
    a_send(8'h04, 2'd2, 8'h21);
    a_send(8'h05, 2'd3, 8'h22);
    tick();
    chk("a_mid_data", a_o_data, av(8'h04, 16'h2103));
    tick();
    chk("a_last_data", a_o_data, av(8'h05, 16'h0132));

    // out-of-range stage write must not disturb ctx2
    a_cfg(2'd2, 2'd3, 2'b11);
    a_send(8'h06, 2'd2, 8'h23);
    tick(); tick();
    chk("a_badstage_data", a_o_data, av(8'h06, 16'h2103));
    tick();

    // 8-port network, registers every second stage (latency 3)
    b_cfg(2'd1, 3'd0, 4'b0001);
    b_cfg(2'd2, 3'd2, 4'b0010);
    b_cfg(2'd3, 3'd3, 4'b1000);
    b_send(8'h30, 2'd0, 8'h70);
    b_send(8'h31, 2'd1, 8'h71);
    chk("b_lat2", b_o_valid, 1'b0);
    b_send(8'h32, 2'd2, 8'h72);
    chk("b_ctx0_valid", b_o_valid, 1'b1);
    chk("b_ctx0_data", b_o_data, bv(8'h30, 32'h01234567));
    chk("b_ctx0_tag", b_o_tag, 8'h70);
    b_send(8'h33, 2'd3, 8'h73);
    chk("b_ctx1_data", b_o_data, bv(8'h31, 32'h10234567));
    tick();
    chk("b_ctx2_data", b_o_data, bv(8'h32, 32'h01634527));
    tick();
    chk("b_ctx3_data", b_o_data, bv(8'h33, 32'h01234765));
    chk("b_ctx3_tag", b_o_tag, 8'h73);
    tick();
    chk("b_drain", b_o_valid, 1'b0);
    chk("b_idle", b_busy, 1'b0);

    // backpressure stream of 20 beats over all four contexts
    sent = 0; got = 0; stall_prev = 1'b0; prev_d = '0; prev_t = '0;
    for (int cyc = 0; cyc < 300 && got < 20; cyc++) begin
      a_o_ready = rdy_pat[cyc % 16];
      if (sent < 20) begin
        a_i_valid = 1'b1;
        a_i_ctx   = 2'(sent % 4);
        a_i_tag   = 8'h40 + 8'(sent);
        a_i_data  = av(8'h80 + 8'(sent), 16'h0123);
      end else begin
        a_i_valid = 1'b0;
      end
      #1;
      chk("a_bp_i_ready", a_i_ready, !(a_o_valid && !a_o_ready));
      if (sent > got) chk("a_bp_busy", a_busy, 1'b1);
      if (stall_prev) begin
        chk("a_bp_hold_data", a_o_data, prev_d);
        chk("a_bp_hold_tag", a_o_tag, prev_t);
      end
      if (a_o_valid && a_o_ready) begin
        if (exp_t_q.size() == 0) begin
          chk("a_bp_unexpected", a_o_valid, 1'b0);
        end else begin
          chk("a_bp_data", a_o_data, exp_d_q.pop_front());
          chk("a_bp_tag", a_o_tag, exp_t_q.pop_front());
          got++;
        end
      end
      if (a_i_valid && a_i_ready) begin
        exp_d_q.push_back(av(8'h80 + 8'(sent), a_ord[sent % 4]));
        exp_t_q.push_back(8'h40 + 8'(sent));
        sent++;
      end
      stall_prev = a_o_valid && !a_o_ready;
      prev_d = a_o_data;
      prev_t = a_o_tag;
      @(posedge clk);
      #1;
    end
    a_i_valid = 1'b0;
    a_o_ready = 1'b1;
    chk("a_bp_count", got, 20);
    for (int w = 0; w < 10 && a_busy; w++) tick();
    chk("a_bp_busy_drop", a_busy, 1'b0);
    chk("a_bp_no_extra", a_o_valid, 1'b0);

    // reset with three beats in flight
    a_send(8'h90, 2'd1, 8'h91);
    a_send(8'h92, 2'd1, 8'h93);
    a_send(8'h94, 2'd1, 8'h95);
    chk("a_mid_inflight", a_o_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("a_mid_rst_valid", a_o_valid, 1'b0);
    chk("a_mid_rst_busy", a_busy, 1'b0);
    chk("a_mid_rst_data", a_o_data, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    a_send(8'hA0, 2'd1, 8'hA1);
    tick(); tick();
    chk("a_post_rst_valid", a_o_valid, 1'b1);
    chk("a_post_rst_data", a_o_data, av(8'hA0, 16'h0123));
    chk("a_post_rst_tag", a_o_tag, 8'hA1);
    b_send(8'hB0, 2'd1, 8'hB1);
    tick(); tick();
    chk("b_post_rst_data", b_o_data, bv(8'hB0, 32'h01234567));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
